// File: rtl/agc_fetch.sv
// agc_fetch: instruction fetch stage in front of the decoder.
// Holds the program counter, keeps at most one read outstanding to instruction
// memory, buffers one word for decode (plus a one-entry skid word while
// decode is stalled), and squashes fetches on redirect or halt.
module agc_fetch #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'o4000
) (
    input  logic              clock,
    input  logic              rst_l,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [14:0]       imem_rdata,
    output logic [14:0]       instr_D,
    output logic [ADDR_W-1:0] pc_D,
    output logic              instr_valid_D,
    input  logic              decode_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_BLOCKED,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [14:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [14:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              halt_pend_q, halt_pend_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              pending;

    // Sequential PC (wraps naturally at the top of the address space) and a
    // flag for a read that is still waiting for its ack.
    assign pc_inc  = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pending = req_q && !imem_ack;

    // Next-state logic: halt beats redirect, redirect beats ack/consume.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        halt_pend_d  = halt_pend_q;
        halted_d     = halted_q;

        if (decode_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (halt) begin
                    out_valid_d = 1'b0;
                    if (pending) begin
                        state_d     = S_DRAIN;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d  = S_HALTED;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                    end
                end else if (redirect) begin
                    out_valid_d = 1'b0;
                    fetch_pc_d  = redirect_pc;
                    if (pending) begin
                        state_d = S_DRAIN;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = redirect_pc;
                    end
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc_q;
                end else if (imem_ack) begin
                    if (!out_valid_q || decode_ready) begin
                        out_instr_d = imem_rdata;
                        out_pc_d    = addr_q;
                        out_valid_d = 1'b1;
                        fetch_pc_d  = pc_inc;
                        addr_d      = pc_inc;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = addr_q;
                        state_d      = S_BLOCKED;
                        req_d        = 1'b0;
                    end
                end
            end

            S_BLOCKED: begin
                if (halt) begin
                    out_valid_d = 1'b0;
                    state_d     = S_HALTED;
                    halted_d    = 1'b1;
                end else if (redirect) begin
                    out_valid_d = 1'b0;
                    fetch_pc_d  = redirect_pc;
                    state_d     = S_RUN;
                    req_d       = 1'b1;
                    addr_d      = redirect_pc;
                end else if (decode_ready) begin
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                    out_valid_d = 1'b1;
                    fetch_pc_d  = pc_inc;
                    state_d     = S_RUN;
                    req_d       = 1'b1;
                    addr_d      = pc_inc;
                end
            end

            S_DRAIN: begin
                out_valid_d = 1'b0;
                if (halt) begin
                    halt_pend_d = 1'b1;
                end else if (redirect && !halt_pend_q) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    if (halt_pend_d) begin
                        state_d  = S_HALTED;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_d;
                    end
                end
            end

            S_HALTED: begin
                out_valid_d = 1'b0;
                req_d       = 1'b0;
                halted_d    = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and output registers; reset may land mid-request and aborts it.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= S_RUN;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            halt_pend_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            halt_pend_q  <= halt_pend_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign instr_D       = out_instr_q;
    assign pc_D          = out_pc_q;
    assign instr_valid_D = out_valid_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_agc_fetch.sv
// tb_agc_fetch: self-checking bench for the agc_fetch instruction fetch stage.
// A memory responder with configurable (or random) latency serves reads from a
// random instruction image and watches the request/ack handshake.
module tb_agc_fetch;

    localparam logic [11:0] RST_PC = 12'o4000;

    logic        clock = 1'b0;
    logic        rst_l = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [14:0] imem_rdata = '0;
    logic [14:0] instr_D;
    logic [11:0] pc_D;
    logic        instr_valid_D;
    logic        decode_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [14:0] mem [0:4095];

    int          lat = 0;
    bit          rand_lat = 1'b0;
    int          cnt = 0;
    int          cur_lat = 0;
    logic        prev_req = 1'b0;
    logic [11:0] prev_addr = '0;

    agc_fetch #(.ADDR_W(12), .RESET_PC(12'o4000)) dut (
        .clock(clock), .rst_l(rst_l),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_D(instr_D), .pc_D(pc_D), .instr_valid_D(instr_valid_D),
        .decode_ready(decode_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted)
    );

    always #5 clock = ~clock;

    // Memory responder: acks a request in its (latency+1)-th cycle and checks
    // that an unacked request stays raised with a stable address.
    always begin
        @(posedge clock);
        #1;
        if (!rst_l) begin
            cnt      = 0;
            prev_req = 1'b0;
            imem_ack = 1'b0;
        end else begin
            if (prev_req && !imem_ack) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_fail++;
                    $display("[TB] FAIL protocol_hold: req=%b addr=%0o, required req=1 addr=%0o",
                             imem_req, imem_addr, prev_addr);
                end
            end
            if (imem_req && prev_req && !imem_ack) begin
                cnt++;
            end else begin
                cnt     = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
            end
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            imem_ack   = imem_req && (cnt >= cur_lat);
            imem_rdata = imem_ack ? mem[imem_addr] : 15'($urandom);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_l        = 1'b0;
        redirect     = 1'b0;
        halt         = 1'b0;
        decode_ready = 1'b0;
        redirect_pc  = '0;
        repeat (2) step();
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        rst_l = 1'b1;
        #2;
        rst_l        = 1'b0;
        decode_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL reset_addr: got %0o want %0o", imem_addr, RST_PC); end
        n_checks++; if (instr_D !== 15'd0) begin n_fail++; $display("[TB] FAIL reset_instr: got %0o want 0", instr_D); end
        n_checks++; if (pc_D !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_pc_D: got %0o want 0", pc_D); end
        n_checks++; if (instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid_D); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        repeat (2) step();
        rst_l = 1'b1;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL reset_first_req: req=%b addr=%0o want 1/%0o", imem_req, imem_addr, RST_PC); end
        n_checks++; if (instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_first_valid: got %b want 0", instr_valid_D); end
    endtask

    task automatic test_zero_wait();
        logic [11:0] exp_pc;
        lat = 0;
        do_reset();
        decode_ready = 1'b1;
        step();
        n_checks++; if (instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL zw_early_valid: got %b want 0", instr_valid_D); end
        for (int k = 0; k < 4; k++) begin
            step();
            exp_pc = RST_PC + 12'(k);
            n_checks++; if (instr_valid_D !== 1'b1) begin n_fail++; $display("[TB] FAIL zw_valid[%0d]: got %b want 1", k, instr_valid_D); end
            n_checks++; if (pc_D !== exp_pc) begin n_fail++; $display("[TB] FAIL zw_pc[%0d]: got %0o want %0o", k, pc_D, exp_pc); end
            n_checks++; if (instr_D !== mem[exp_pc]) begin n_fail++; $display("[TB] FAIL zw_instr[%0d]: got %0o want %0o", k, instr_D, mem[exp_pc]); end
        end
    endtask

    task automatic test_backpressure();
        lat = 0;
        do_reset();
        decode_ready = 1'b0;
        step();
        step();
        n_checks++; if (instr_valid_D !== 1'b1 || pc_D !== RST_PC) begin n_fail++; $display("[TB] FAIL bp_first: valid=%b pc=%0o want 1/%0o", instr_valid_D, pc_D, RST_PC); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_drop[%0d]: got %b want 0", i, imem_req); end
            n_checks++; if (pc_D !== RST_PC || instr_D !== mem[RST_PC]) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: pc=%0o instr=%0o want %0o/%0o", i, pc_D, instr_D, RST_PC, mem[RST_PC]); end
        end
        decode_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            n_checks++; if (instr_valid_D !== 1'b1 || pc_D !== RST_PC + 12'(k)) begin n_fail++; $display("[TB] FAIL bp_release_pc[%0d]: valid=%b pc=%0o want 1/%0o", k, instr_valid_D, pc_D, RST_PC + 12'(k)); end
            n_checks++; if (instr_D !== mem[RST_PC + 12'(k)]) begin n_fail++; $display("[TB] FAIL bp_release_instr[%0d]: got %0o want %0o", k, instr_D, mem[RST_PC + 12'(k)]); end
        end
    endtask

    task automatic test_redirect_drain();
        lat = 2;
        do_reset();
        decode_ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 12'o2100;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_hold[%0d]: req=%b addr=%0o valid=%b want 1/%0o/0", i, imem_req, imem_addr, instr_valid_D, RST_PC); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 12'o2100 || instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_new_req[%0d]: req=%b addr=%0o valid=%b want 1/2100/0", i, imem_req, imem_addr, instr_valid_D); end
            step();
        end
        n_checks++; if (instr_valid_D !== 1'b1 || pc_D !== 12'o2100 || instr_D !== mem[12'o2100]) begin n_fail++; $display("[TB] FAIL drain_first_word: valid=%b pc=%0o instr=%0o want 1/2100/%0o", instr_valid_D, pc_D, instr_D, mem[12'o2100]); end
    endtask

    task automatic test_redirect_with_ack();
        logic [11:0] rpc;
        bit          got;
        lat = 2;
        do_reset();
        decode_ready = 1'b1;
        repeat (3) step();
        rpc         = 12'($urandom_range(0, 'o3777));
        redirect    = 1'b1;
        redirect_pc = rpc;
        step();
        redirect = 1'b0;
        n_checks++; if (instr_valid_D !== 1'b0 || imem_req !== 1'b1 || imem_addr !== rpc) begin n_fail++; $display("[TB] FAIL rack_after: valid=%b req=%b addr=%0o want 0/1/%0o", instr_valid_D, imem_req, imem_addr, rpc); end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (instr_valid_D === 1'b1) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("[TB] FAIL rack_timeout: no valid word, want one within 8 cycles"); end
        if (got) begin
            n_checks++; if (pc_D !== rpc || instr_D !== mem[rpc]) begin n_fail++; $display("[TB] FAIL rack_word: pc=%0o instr=%0o want %0o/%0o", pc_D, instr_D, rpc, mem[rpc]); end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_pc;
        bit          got;
        lat = 0;
        do_reset();
        decode_ready = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 12'o7776;
        step();
        redirect = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (instr_valid_D === 1'b1) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("[TB] FAIL wrap_timeout: no valid word, want one within 8 cycles"); end
        exp_pc = 12'o7776;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (instr_valid_D !== 1'b1 || pc_D !== exp_pc || instr_D !== mem[exp_pc]) begin n_fail++; $display("[TB] FAIL wrap_seq[%0d]: valid=%b pc=%0o instr=%0o want 1/%0o/%0o", k, instr_valid_D, pc_D, instr_D, exp_pc, mem[exp_pc]); end
            exp_pc = exp_pc + 12'd1;
            step();
        end
    endtask

    task automatic test_halt();
        lat = 2;
        do_reset();
        decode_ready = 1'b1;
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || halted !== 1'b0 || instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_drain0: req=%b halted=%b valid=%b want 1/0/0", imem_req, halted, instr_valid_D); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_drain1: req=%b addr=%0o halted=%b want 1/%0o/0", imem_req, imem_addr, halted, RST_PC); end
        step();
        n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_done: halted=%b req=%b want 1/0", halted, imem_req); end
        redirect    = 1'b1;
        redirect_pc = 12'o100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_ignore_redirect[%0d]: halted=%b req=%b valid=%b want 1/0/0", i, halted, imem_req, instr_valid_D); end
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        lat = 0;
        do_reset();
        decode_ready = 1'b1;
        repeat (4) step();
        n_checks++; if (instr_valid_D !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre: valid=%b req=%b want 1/1", instr_valid_D, imem_req); end
        #2;
        rst_l = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || halted !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ctrl: req=%b addr=%0o halted=%b want 0/%0o/0", imem_req, imem_addr, halted, RST_PC); end
        n_checks++; if (instr_valid_D !== 1'b0 || instr_D !== 15'd0 || pc_D !== 12'd0) begin n_fail++; $display("[TB] FAIL midrst_data: valid=%b instr=%0o pc=%0o want 0/0/0", instr_valid_D, instr_D, pc_D); end
        repeat (2) step();
        rst_l = 1'b1;
    endtask

    task automatic test_random_stream();
        logic [11:0] exp_pc;
        int          consumed;
        bit          r;
        rand_lat = 1'b1;
        do_reset();
        exp_pc   = RST_PC;
        consumed = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            r = ($urandom_range(0, 9) < 7);
            decode_ready = r;
            if ($urandom_range(0, 39) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 12'($urandom);
                exp_pc      = redirect_pc;
            end else begin
                redirect = 1'b0;
                if (instr_valid_D === 1'b1 && r) begin
                    n_checks++; if (pc_D !== exp_pc || instr_D !== mem[exp_pc]) begin n_fail++; $display("[TB] FAIL rand_stream: pc=%0o instr=%0o want %0o/%0o", pc_D, instr_D, exp_pc, mem[exp_pc]); end
                    exp_pc = exp_pc + 12'd1;
                    consumed++;
                end
            end
        end
        redirect     = 1'b0;
        decode_ready = 1'b0;
        rand_lat     = 1'b0;
        n_checks++; if (consumed < 200) begin n_fail++; $display("[TB] FAIL rand_liveness: consumed %0d words, want at least 200", consumed); end
    endtask

    // Runaway guard in case the design stops making progress.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 15'($urandom);
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_drain();
        test_redirect_with_ack();
        test_wrap();
        test_halt();
        test_reset_mid_request();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
